odesa_train_seq: RTL and testbench
==================================

ODESA_TRAIN_SEQ -- requirements
Module: odesa_train_seq

Interface
- REQ-001 SHALL have parameter p_width, default 9: bit width of one spike-time field and of the intra-sample time counter.
- REQ-002 SHALL have parameter p_sample_num, default 75: samples per epoch; legal range 1..128.
- REQ-003 SHALL have parameter p_sample_len, default 80: PLAY window length in cycles; legal range 1..2^p_width-1.
- REQ-004 SHALL have parameter p_pattern_delay, default 5000: GAP length in cycles; legal range 1..8191.
- REQ-005 SHALL have parameter p_epochs, default 350: training epochs; legal range 1..511.
- REQ-006 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
- REQ-007 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
- REQ-008 SHALL have port i_start, input, 1: single-cycle pulse that starts training.
- REQ-009 SHALL have port i_abort, input, 1: single-cycle pulse that cancels training.
- REQ-010 SHALL have port o_rd_addr, output, 7: sample-memory address.
- REQ-011 SHALL have port i_rd_data, input, 4*p_width+2: sample word; bits [1:0] = label code, field k (k=1..4) at [2+k*p_width-1 : 2+(k-1)*p_width] = spike time T_k; valid exactly 1 cycle after o_rd_addr.
- REQ-012 SHALL have port o_event, output, 4 ([4:1]): spike pulses to L1.
- REQ-013 SHALL have port o_label, output, 3 ([3:1]): one-hot class label to L2.
- REQ-014 SHALL have port o_learn_en, output, 1: learning enable.
- REQ-015 SHALL have port o_end_of_epochs, output, 1: training complete; steers the external event mux to live input.
- REQ-016 SHALL have port o_busy, output, 1: training in progress.
- REQ-017 SHALL have port o_epoch_cnt, output, 9: completed epochs.
- REQ-018 SHALL have port o_sample_idx, output, 7: current sample index.

Function
- REQ-019 SHALL implement the FSM states IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- REQ-020 SHALL go IDLE->FETCH on i_start; i_start SHALL be ignored in FETCH/LOAD/PLAY/GAP.
- REQ-021 SHALL drive o_rd_addr=o_sample_idx in FETCH (1 cycle), then go to LOAD.
- REQ-022 SHALL capture i_rd_data in LOAD (1 cycle), then go to PLAY with time counter t=0.
- REQ-023 SHALL hold PLAY for exactly p_sample_len cycles, t incrementing 0..p_sample_len-1, then go to GAP.
- REQ-024 SHALL assert o_event[k] for exactly one cycle, during the PLAY cycle where t==T_k.
- REQ-025 SHALL never fire channel k when T_k>=p_sample_len; channels with equal T_k SHALL fire in the same cycle.
- REQ-026 SHALL decode the label code as 00->3'b001, 01->3'b010, 10->3'b100, 11->3'b000.
- REQ-027 SHALL hold o_label and o_learn_en only during PLAY; o_learn_en SHALL be 0 for label code 11.
- REQ-028 SHALL hold GAP for p_pattern_delay cycles with o_event, o_label and o_learn_en at 0.
- REQ-029 SHALL, at GAP end when o_sample_idx<p_sample_num-1, increment o_sample_idx and go to FETCH.
- REQ-030 SHALL, at GAP end otherwise, clear o_sample_idx, increment o_epoch_cnt, and go to FETCH, or to DONE if the new count equals p_epochs.
- REQ-031 SHALL give a per-sample period of exactly p_sample_len+p_pattern_delay+2 cycles, with no idle cycle between samples or epochs.
- REQ-032 SHALL set o_end_of_epochs=1 in DONE, sticky; all other outputs SHALL be 0 except o_epoch_cnt=p_epochs.
- REQ-033 SHALL, on i_start in DONE, clear o_end_of_epochs and both counters and go to FETCH.
- REQ-034 SHALL, on i_abort in any state, go to IDLE next cycle with all outputs and counters 0; i_abort SHALL win over a simultaneous i_start.
- REQ-035 SHALL set o_busy=1 exactly in FETCH, LOAD, PLAY and GAP.
- REQ-036 SHALL register all outputs.

Reset
- REQ-037 SHALL, while i_rst_n=0 and regardless of clock, force IDLE, all outputs 0 and all counters 0.
- REQ-038 SHALL ignore i_start in the first cycle after reset release is sampled; reset mid-operation SHALL discard the captured sample word.

Verification (p_sample_num=2, p_sample_len=8, p_pattern_delay=3, p_epochs=2, p_width=9)
- REQ-039 SHALL be covered: start pulse, mem[0]={T=1,3,3,9, code 01} -> o_event[1] at t=1, o_event[2] and o_event[3] together at t=3, o_event[4] never; o_label=3'b010 for 8 cycles.
- REQ-040 SHALL be covered: full run -> 4 samples at 13-cycle period, o_end_of_epochs rises 52 cycles after the first FETCH, o_epoch_cnt=2.
- REQ-041 SHALL be covered: code 11 sample -> o_label=0 and o_learn_en=0, while events still fire.
- REQ-042 SHALL be covered: abort in PLAY at t=4 -> next cycle IDLE with all outputs 0; a later start replays sample 0, epoch 0.
- REQ-043 SHALL be covered: start in PLAY -> no effect; start in DONE -> o_end_of_epochs=0 next cycle and the run restarts.
- REQ-044 SHALL be covered: i_rst_n low mid-GAP -> outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/odesa_train_seq.sv
// ---------------------------------------------------------------------------
// odesa_train_seq
//   Training sequencer. It walks the sample memory one word at a time, replays
//   each word's four spike times as single-cycle pulses inside a PLAY window,
//   presents the decoded class label alongside the pulses, and inserts an
//   inter-pattern GAP after each sample. The whole sample set is repeated for
//   p_epochs epochs. After the last epoch it parks in DONE with
//   o_end_of_epochs held high.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   i_start         start pulse, honoured in IDLE and DONE only
//   i_abort         abort pulse, honoured in every state, wins over i_start
//   o_rd_addr       sample-memory address, valid during FETCH
//   i_rd_data       sample word {T4,T3,T2,T1,label_code}, valid one cycle
//                   after o_rd_addr
//   o_event[3:0]    spike pulses (channel k on bit k-1)
//   o_label[2:0]    one-hot class label, driven during PLAY only
//   o_learn_en      learning enable, driven during PLAY only
//   o_end_of_epochs sticky completion flag
//   o_busy          high in FETCH, LOAD, PLAY and GAP
//   o_epoch_cnt     number of completed epochs
//   o_sample_idx    index of the sample being processed
// ---------------------------------------------------------------------------
module odesa_train_seq #(
  parameter int unsigned p_width         = 9,
  parameter int unsigned p_sample_num    = 75,
  parameter int unsigned p_sample_len    = 80,
  parameter int unsigned p_pattern_delay = 5000,
  parameter int unsigned p_epochs        = 350
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic [6:0]             o_rd_addr,
  input  logic [4*p_width+1:0]   i_rd_data,
  output logic [3:0]             o_event,
  output logic [2:0]             o_label,
  output logic                   o_learn_en,
  output logic                   o_end_of_epochs,
  output logic                   o_busy,
  output logic [8:0]             o_epoch_cnt,
  output logic [6:0]             o_sample_idx
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_t;

  localparam int unsigned LAST_T_I   = p_sample_len - 1;
  localparam int unsigned LAST_IDX_I = p_sample_num - 1;
  localparam int unsigned LAST_GAP_I = p_pattern_delay - 1;
  localparam int unsigned EPOCHS_I   = p_epochs;

  localparam logic [p_width-1:0] LAST_T   = LAST_T_I[p_width-1:0];
  localparam logic [6:0]         LAST_IDX = LAST_IDX_I[6:0];
  localparam logic [12:0]        LAST_GAP = LAST_GAP_I[12:0];
  localparam logic [8:0]         EPOCHS   = EPOCHS_I[8:0];

  // Internal state
  state_t                 state, state_n;
  logic [p_width-1:0]     t, t_n;
  logic [12:0]            gap, gap_n;
  logic [4*p_width+1:0]   word, word_n;
  logic                   armed;

  // Next values of the registered outputs
  logic [6:0]             idx_n;
  logic [8:0]             ep_n;
  logic                   eod_n;
  logic [6:0]             rd_addr_n;
  logic [3:0]             event_n;
  logic [2:0]             label_n;
  logic                   learn_n;
  logic                   busy_n;
  logic                   play_n;
  logic [8:0]             ep_inc;

  assign ep_inc = o_epoch_cnt + 9'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      t               <= '0;
      gap             <= '0;
      word            <= '0;
      armed           <= 1'b0;
      o_rd_addr       <= '0;
      o_event         <= '0;
      o_label         <= '0;
      o_learn_en      <= 1'b0;
      o_end_of_epochs <= 1'b0;
      o_busy          <= 1'b0;
      o_epoch_cnt     <= '0;
      o_sample_idx    <= '0;
    end else begin
      state           <= state_n;
      t               <= t_n;
      gap             <= gap_n;
      word            <= word_n;
      armed           <= 1'b1;
      o_rd_addr       <= rd_addr_n;
      o_event         <= event_n;
      o_label         <= label_n;
      o_learn_en      <= learn_n;
      o_end_of_epochs <= eod_n;
      o_busy          <= busy_n;
      o_epoch_cnt     <= ep_n;
      o_sample_idx    <= idx_n;
    end
  end

  // Outputs are registered from the next-state values so that every output
  // lines up with the state it belongs to. In LOAD the memory word is taken
  // straight from i_rd_data so the t=0 pulses are ready on PLAY entry.
  always_comb begin
    state_n = state;
    t_n     = t;
    gap_n   = gap;
    word_n  = word;
    idx_n   = o_sample_idx;
    ep_n    = o_epoch_cnt;
    eod_n   = o_end_of_epochs;

    case (state)
      IDLE: begin
        // armed stays low for the first edge after reset release
        if (i_start && armed) begin
          state_n = FETCH;
        end
      end
      FETCH: begin
        state_n = LOAD;
      end
      LOAD: begin
        word_n  = i_rd_data;
        t_n     = '0;
        state_n = PLAY;
      end
      PLAY: begin
        if (t == LAST_T) begin
          gap_n   = '0;
          state_n = GAP;
        end else begin
          t_n = t + 1'b1;
        end
      end
      GAP: begin
        if (gap == LAST_GAP) begin
          if (o_sample_idx < LAST_IDX) begin
            idx_n   = o_sample_idx + 7'd1;
            state_n = FETCH;
          end else begin
            idx_n = '0;
            ep_n  = ep_inc;
            if (ep_inc == EPOCHS) begin
              eod_n   = 1'b1;
              state_n = DONE;
            end else begin
              state_n = FETCH;
            end
          end
        end else begin
          gap_n = gap + 13'd1;
        end
      end
      DONE: begin
        if (i_start) begin
          eod_n   = 1'b0;
          idx_n   = '0;
          ep_n    = '0;
          state_n = FETCH;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (i_abort) begin
      state_n = IDLE;
      t_n     = '0;
      gap_n   = '0;
      word_n  = '0;
      idx_n   = '0;
      ep_n    = '0;
      eod_n   = 1'b0;
    end

    play_n    = (state_n == PLAY);
    busy_n    = (state_n == FETCH) || (state_n == LOAD) ||
                (state_n == PLAY)  || (state_n == GAP);
    rd_addr_n = (state_n == FETCH) ? idx_n : '0;

    // t never reaches p_sample_len, so late spike times never fire
    event_n = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      event_n[k] = play_n && (t_n == word_n[2 + k*p_width +: p_width]);
    end

    label_n = '0;
    learn_n = 1'b0;
    if (play_n) begin
      case (word_n[1:0])
        2'b00:   label_n = 3'b001;
        2'b01:   label_n = 3'b010;
        2'b10:   label_n = 3'b100;
        default: label_n = 3'b000;
      endcase
      learn_n = (word_n[1:0] != 2'b11);
    end
  end

endmodule

// File: tb/tb_odesa_train_seq.sv
module tb_odesa_train_seq;

  localparam int W      = 9;
  localparam int NUM    = 2;
  localparam int LEN    = 8;
  localparam int DLY    = 3;
  localparam int EP     = 2;
  localparam int PERIOD = LEN + DLY + 2;
  localparam int TOTAL  = NUM * EP * PERIOD;

  typedef struct packed {
    logic [6:0] rd_addr;
    logic [3:0] ev;
    logic [2:0] label;
    logic       learn;
    logic       eod;
    logic       busy;
    logic [8:0] epoch;
    logic [6:0] idx;
  } obs_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [6:0]      rd_addr;
  logic [4*W+1:0]  rd_data;
  logic [3:0]      ev;
  logic [2:0]      label;
  logic            learn_en;
  logic            eod;
  logic            busy;
  logic [8:0]      epoch_cnt;
  logic [6:0]      sample_idx;

  logic [4*W+1:0]  mem [128];

  int vectors;
  int miscompares;

  odesa_train_seq #(
    .p_width        (W),
    .p_sample_num   (NUM),
    .p_sample_len   (LEN),
    .p_pattern_delay(DLY),
    .p_epochs       (EP)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .o_rd_addr      (rd_addr),
    .i_rd_data      (rd_data),
    .o_event        (ev),
    .o_label        (label),
    .o_learn_en     (learn_en),
    .o_end_of_epochs(eod),
    .o_busy         (busy),
    .o_epoch_cnt    (epoch_cnt),
    .o_sample_idx   (sample_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read sample memory: data valid one cycle after the address
  always @(posedge clk) rd_data <= mem[rd_addr];

  function automatic obs_t observe();
    return {rd_addr, ev, label, learn_en, eod, busy, epoch_cnt, sample_idx};
  endfunction

  function automatic logic [4*W+1:0] make_word(int t1, int t2, int t3, int t4, int code);
    return {9'(t4), 9'(t3), 9'(t2), 9'(t1), 2'(code)};
  endfunction

  // Expected outputs n cycles after the first FETCH of a run: each sample
  // occupies PERIOD cycles (FETCH, LOAD, LEN play cycles, DLY gap cycles).
  function automatic obs_t model(int n);
    obs_t e;
    int s, w, t, code, tk;
    logic [4*W+1:0] wd;
    e = '0;
    if (n >= TOTAL) begin
      e.eod   = 1'b1;
      e.epoch = 9'(EP);
      return e;
    end
    s = n / PERIOD;
    w = n % PERIOD;
    e.busy  = 1'b1;
    e.idx   = 7'(s % NUM);
    e.epoch = 9'(s / NUM);
    if (w == 0) e.rd_addr = 7'(s % NUM);
    if (w >= 2 && w < 2 + LEN) begin
      t    = w - 2;
      wd   = mem[s % NUM];
      code = int'(wd[1:0]);
      for (int k = 0; k < 4; k++) begin
        tk = int'(wd[2 + k*W +: W]);
        if (tk == t) e.ev[k] = 1'b1;
      end
      e.label = (code == 3) ? 3'b000 : 3'(1 << code);
      e.learn = (code != 3);
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if (observe() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=0", observe());
    end
    @(negedge clk);
    vectors++;
    if (observe() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL reset_hold got=%h exp=0", observe());
    end
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (observe() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL start_after_release got=%h exp=0", observe());
    end
  endtask

  task automatic test_directed_run();
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[0] = make_word(1, 3, 3, 9, 1);
    mem[1] = make_word(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                       int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                       int'($urandom_range(0, 3)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= TOTAL; n++) begin
      vectors++;
      if (observe() !== model(n)) begin
        miscompares++;
        $display("FAIL directed n=%0d got=%h exp=%h", n, observe(), model(n));
      end
      if (n == 3) begin
        vectors++;
        if (ev !== 4'b0001) begin
          miscompares++;
          $display("FAIL event_t1 got=%b exp=0001", ev);
        end
      end
      if (n == 5) begin
        vectors++;
        if (ev !== 4'b0110) begin
          miscompares++;
          $display("FAIL event_t3 got=%b exp=0110", ev);
        end
      end
      if (n == TOTAL) begin
        vectors++;
        if (eod !== 1'b1 || epoch_cnt !== 9'd2) begin
          miscompares++;
          $display("FAIL done_at_52 got eod=%b ep=%0d exp eod=1 ep=2", eod, epoch_cnt);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_in_done_and_play();
    for (int i = 0; i < NUM; i++)
      mem[i] = make_word(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                         int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                         int'($urandom_range(0, 3)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= TOTAL; n++) begin
      vectors++;
      if (observe() !== model(n)) begin
        miscompares++;
        $display("FAIL restart n=%0d got=%h exp=%h", n, observe(), model(n));
      end
      if (n == 0) begin
        vectors++;
        if (eod !== 1'b0) begin
          miscompares++;
          $display("FAIL eod_clear got=%b exp=0", eod);
        end
      end
      start = (n == 6);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_code11();
    int fired;
    fired = 0;
    for (int i = 0; i < NUM; i++)
      mem[i] = make_word(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 2 * PERIOD; n++) begin
      vectors++;
      if (observe() !== model(n)) begin
        miscompares++;
        $display("FAIL code11 n=%0d got=%h exp=%h", n, observe(), model(n));
      end
      if (n >= 2 && n < 2 + LEN) fired += int'($countones(ev));
      @(negedge clk);
    end
    vectors++;
    if (fired != 4) begin
      miscompares++;
      $display("FAIL code11_events got=%0d exp=4", fired);
    end
  endtask

  task automatic test_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (observe() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL abort_midrun got=%h exp=0", observe());
    end
    mem[0] = make_word(int'($urandom_range(0, 7)), 2, int'($urandom_range(0, 11)), 5, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      vectors++;
      if (observe() !== model(n)) begin
        miscompares++;
        $display("FAIL pre_abort n=%0d got=%h exp=%h", n, observe(), model(n));
      end
      if (n < 6) @(negedge clk);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    vectors++;
    if (observe() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL abort_in_play got=%h exp=0", observe());
    end
    @(negedge clk);
    vectors++;
    if (observe() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL abort_idle_hold got=%h exp=0", observe());
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 15; n++) begin
      vectors++;
      if (observe() !== model(n)) begin
        miscompares++;
        $display("FAIL replay n=%0d got=%h exp=%h", n, observe(), model(n));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 11; n++) begin
      vectors++;
      if (observe() !== model(n)) begin
        miscompares++;
        $display("FAIL pre_reset n=%0d got=%h exp=%h", n, observe(), model(n));
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (observe() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL reset_in_gap got=%h exp=0", observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (observe() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL start_first_cycle got=%h exp=0", observe());
    end
    mem[0] = make_word(0, int'($urandom_range(0, 11)), 7, int'($urandom_range(0, 11)), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 13; n++) begin
      vectors++;
      if (observe() !== model(n)) begin
        miscompares++;
        $display("FAIL post_reset n=%0d got=%h exp=%h", n, observe(), model(n));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    start       = 1'b0;
    abort       = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    test_reset();
    test_directed_run();
    test_start_in_done_and_play();
    test_code11();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
